// File: rtl/xix_prefix_sequencer.sv
// Tracks DD/FD prefixes, latches the indexed opcode into Source and runs the XPT step counter
// that drives the IX/IY decoder; not_enable opens the decoder only while an indexed opcode executes.
module xix_prefix_sequencer #(
    parameter logic [7:0] PREFIX_IX = 8'hDD,
    parameter logic [7:0] PREFIX_IY = 8'hFD,
    parameter logic [4:0] XPT_MAX   = 5'd31
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       Fetch_Valid,
    input  logic [7:0] Fetch_Data,
    input  logic       Step_Enable,
    input  logic       PR_Reset_XPT,
    input  logic       P2_Set_CM1,
    input  logic       P2_Reset_XIX,
    input  logic       P2_Reset_XIY,
    output logic       not_enable,
    output logic       is_Y,
    output logic [4:0] XPT,
    output logic [4:0] notXPT,
    output logic [7:0] Source,
    output logic [7:0] notSource,
    output logic       Prefix_Pending,
    output logic       Prefix_Drop,
    output logic       XPT_Overflow
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREFIX = 2'd1,
        ST_EXEC   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_is_y;
    logic       w_is_y_nxt;
    logic [4:0] r_xpt;
    logic [4:0] w_xpt_nxt;
    logic [4:0] r_not_xpt;
    logic [7:0] r_source;
    logic [7:0] w_source_nxt;
    logic [7:0] r_not_source;
    logic       r_drop;
    logic       w_drop_nxt;
    logic       r_ovf;
    logic       w_ovf_nxt;

    logic       w_fetch_prefix;
    logic       w_fetch_escape;
    logic       w_fetch_is_iy;
    logic       w_exit;

    assign w_fetch_is_iy  = (Fetch_Data == PREFIX_IY);
    assign w_fetch_prefix = Fetch_Valid && ((Fetch_Data == PREFIX_IX) || w_fetch_is_iy);
    assign w_fetch_escape = Fetch_Valid && ((Fetch_Data == 8'hCB) || (Fetch_Data == 8'hED));
    // Only the reset matching the current index register ends the instruction.
    assign w_exit = P2_Set_CM1 || (P2_Reset_XIX && !r_is_y) || (P2_Reset_XIY && r_is_y);

    always_comb begin
        w_state_nxt  = r_state;
        w_is_y_nxt   = r_is_y;
        w_xpt_nxt    = r_xpt;
        w_source_nxt = r_source;
        w_drop_nxt   = 1'b0;
        w_ovf_nxt    = r_ovf;
        case (r_state)
            ST_IDLE: begin
                if (w_fetch_prefix) begin
                    w_state_nxt = ST_PREFIX;
                    w_is_y_nxt  = w_fetch_is_iy;
                end
            end
            ST_PREFIX: begin
                if (w_fetch_prefix) begin
                    w_is_y_nxt = w_fetch_is_iy;
                end else if (w_fetch_escape) begin
                    w_state_nxt = ST_IDLE;
                    w_drop_nxt  = 1'b1;
                end else if (Fetch_Valid) begin
                    w_state_nxt  = ST_EXEC;
                    w_source_nxt = Fetch_Data;
                    w_xpt_nxt    = 5'd0;
                end
            end
            ST_EXEC: begin
                if (w_exit) begin
                    w_xpt_nxt = 5'd0;
                    // A prefix fetched in the closing cycle starts the next indexed op directly.
                    if (w_fetch_prefix) begin
                        w_state_nxt = ST_PREFIX;
                        w_is_y_nxt  = w_fetch_is_iy;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (PR_Reset_XPT) begin
                    w_xpt_nxt = 5'd0;
                end else if (Step_Enable) begin
                    if (r_xpt == XPT_MAX) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_xpt_nxt = r_xpt + 5'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_xpt_nxt   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_is_y       <= 1'b0;
            r_xpt        <= 5'd0;
            r_not_xpt    <= 5'h1F;
            r_source     <= 8'h00;
            r_not_source <= 8'hFF;
            r_drop       <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_is_y       <= w_is_y_nxt;
            r_xpt        <= w_xpt_nxt;
            r_not_xpt    <= ~w_xpt_nxt;
            r_source     <= w_source_nxt;
            r_not_source <= ~w_source_nxt;
            r_drop       <= w_drop_nxt;
            r_ovf        <= w_ovf_nxt;
        end
    end

    assign not_enable     = (r_state != ST_EXEC);
    assign Prefix_Pending = (r_state == ST_PREFIX);
    assign is_Y           = r_is_y;
    assign XPT            = r_xpt;
    assign notXPT         = r_not_xpt;
    assign Source         = r_source;
    assign notSource      = r_not_source;
    assign Prefix_Drop    = r_drop;
    assign XPT_Overflow   = r_ovf;

endmodule

// File: tb/tb_xix_prefix_sequencer.sv
// Scoreboarded bench for xix_prefix_sequencer: directed test-plan sequences followed by random traffic.
module tb_xix_prefix_sequencer;

    typedef struct packed {
        logic       ne;
        logic       y;
        logic [4:0] xpt;
        logic [4:0] nxpt;
        logic [7:0] src;
        logic [7:0] nsrc;
        logic       pp;
        logic       pd;
        logic       ov;
    } obs_t;

    localparam int M_IDLE = 0;
    localparam int M_PRE  = 1;
    localparam int M_EXEC = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       Fetch_Valid = 1'b0;
    logic [7:0] Fetch_Data = 8'h00;
    logic       Step_Enable = 1'b0;
    logic       PR_Reset_XPT = 1'b0;
    logic       P2_Set_CM1 = 1'b0;
    logic       P2_Reset_XIX = 1'b0;
    logic       P2_Reset_XIY = 1'b0;
    logic       not_enable;
    logic       is_Y;
    logic [4:0] XPT;
    logic [4:0] notXPT;
    logic [7:0] Source;
    logic [7:0] notSource;
    logic       Prefix_Pending;
    logic       Prefix_Drop;
    logic       XPT_Overflow;

    xix_prefix_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .Fetch_Valid    (Fetch_Valid),
        .Fetch_Data     (Fetch_Data),
        .Step_Enable    (Step_Enable),
        .PR_Reset_XPT   (PR_Reset_XPT),
        .P2_Set_CM1     (P2_Set_CM1),
        .P2_Reset_XIX   (P2_Reset_XIX),
        .P2_Reset_XIY   (P2_Reset_XIY),
        .not_enable     (not_enable),
        .is_Y           (is_Y),
        .XPT            (XPT),
        .notXPT         (notXPT),
        .Source         (Source),
        .notSource      (notSource),
        .Prefix_Pending (Prefix_Pending),
        .Prefix_Drop    (Prefix_Drop),
        .XPT_Overflow   (XPT_Overflow)
    );

    always #5 clock = ~clock;

    obs_t act;
    assign act = {not_enable, is_Y, XPT, notXPT, Source, notSource,
                  Prefix_Pending, Prefix_Drop, XPT_Overflow};

    obs_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_smp  = 0;

    // Reference model state
    int       m_st;
    bit       m_y;
    int       m_xpt;
    bit [7:0] m_src;
    bit       m_drop;
    bit       m_ovf;

    function automatic obs_t model_obs();
        obs_t o;
        o.ne   = (m_st != M_EXEC);
        o.y    = m_y;
        o.xpt  = 5'(m_xpt);
        o.nxpt = ~5'(m_xpt);
        o.src  = m_src;
        o.nsrc = ~m_src;
        o.pp   = (m_st == M_PRE);
        o.pd   = m_drop;
        o.ov   = m_ovf;
        return o;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_y = 0; m_xpt = 0; m_src = 8'h00; m_drop = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit fv, input bit [7:0] fd, input bit se, input bit pr,
                              input bit cm, input bit rx, input bit ry);
        bit pfx;
        bit ext;
        pfx    = fv && (fd == 8'hDD || fd == 8'hFD);
        m_drop = 0;
        if (m_st == M_IDLE) begin
            if (pfx) begin m_st = M_PRE; m_y = (fd == 8'hFD); end
        end else if (m_st == M_PRE) begin
            if (pfx) m_y = (fd == 8'hFD);
            else if (fv && (fd == 8'hCB || fd == 8'hED)) begin m_st = M_IDLE; m_drop = 1; end
            else if (fv) begin m_st = M_EXEC; m_src = fd; m_xpt = 0; end
        end else begin
            ext = cm || (rx && !m_y) || (ry && m_y);
            if (ext) begin
                m_xpt = 0;
                if (pfx) begin m_st = M_PRE; m_y = (fd == 8'hFD); end
                else m_st = M_IDLE;
            end else if (pr) begin
                m_xpt = 0;
            end else if (se) begin
                if (m_xpt == 31) m_ovf = 1;
                else m_xpt = m_xpt + 1;
            end
        end
    endtask

    // Monitor: samples after every rising clock and after every async reset assertion.
    always begin
        obs_t e;
        @(posedge clock or posedge reset);
        #1;
        n_smp++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (act === e) n_pass++;
            else $display("FAIL outputs sample %0d: got ne=%b y=%b xpt=%0d nxpt=%h src=%h nsrc=%h pp=%b pd=%b ov=%b, expected ne=%b y=%b xpt=%0d nxpt=%h src=%h nsrc=%h pp=%b pd=%b ov=%b",
                          n_smp, act.ne, act.y, act.xpt, act.nxpt, act.src, act.nsrc, act.pp, act.pd, act.ov,
                          e.ne, e.y, e.xpt, e.nxpt, e.src, e.nsrc, e.pp, e.pd, e.ov);
        end
    end

    // One clock cycle of stimulus, called at a falling edge.
    task automatic cyc(input bit fv, input bit [7:0] fd, input bit se, input bit pr,
                       input bit cm, input bit rx, input bit ry);
        Fetch_Valid = fv; Fetch_Data = fd; Step_Enable = se; PR_Reset_XPT = pr;
        P2_Set_CM1 = cm; P2_Reset_XIX = rx; P2_Reset_XIY = ry;
        model_step(fv, fd, se, pr, cm, rx, ry);
        exp_q.push_back(model_obs());
        @(negedge clock);
    endtask

    task automatic fetch(input bit [7:0] b);
        cyc(1, b, 0, 0, 0, 0, 0);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 1, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle with busy inputs, checked before the next edge.
    task automatic do_reset();
        Step_Enable = 1; Fetch_Valid = 1; Fetch_Data = 8'hDD; P2_Set_CM1 = 0;
        PR_Reset_XPT = 0; P2_Reset_XIX = 0; P2_Reset_XIY = 0;
        model_reset();
        exp_q.push_back(model_obs());
        #2 reset = 1;
        #1;
        exp_q.push_back(model_obs());
        @(negedge clock);
        reset = 0;
        Fetch_Valid = 0; Step_Enable = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clock);
        do_reset();

        // IX instruction: DD 21, three steps, IX exit
        fetch(8'hDD);
        fetch(8'h21);
        step(3);
        cyc(0, 8'h00, 0, 0, 0, 1, 0);
        cyc(0, 8'h00, 1, 0, 0, 0, 0);

        // Repeated prefixes, last one wins
        fetch(8'hFD); fetch(8'hDD); fetch(8'hFD); fetch(8'h7E);
        step(1);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);

        // Prefix cancelled by CB
        fetch(8'hDD); fetch(8'hCB);
        cyc(0, 8'h00, 1, 1, 1, 1, 1);

        // PR_Reset_XPT beats Step_Enable, then saturation
        fetch(8'hDD); fetch(8'h10);
        step(5);
        cyc(0, 8'h00, 1, 1, 0, 0, 0);
        step(40);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);

        // Mismatched reset ignored, exit chained with an FD prefix
        fetch(8'hDD); fetch(8'h30);
        cyc(0, 8'h00, 1, 0, 0, 0, 1);
        cyc(1, 8'hFD, 0, 0, 1, 0, 0);
        fetch(8'h44);
        cyc(1, 8'h55, 1, 0, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0, 0, 1);

        // Async reset at XPT = 7
        fetch(8'hDD); fetch(8'h21);
        step(7);
        do_reset();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            bit [7:0] b;
            int       r;
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'hDD;
            else if (r == 2) b = 8'hFD;
            else if (r == 3) b = 8'hCB;
            else if (r == 4) b = 8'hED;
            else b = 8'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
            else cyc($urandom_range(0, 9) < 3, b, $urandom_range(0, 9) < 6,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
        end

        @(negedge clock);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/xix_prefix_sequencer.md
Name: xix_prefix_sequencer

Overview:
- Upstream feeder of the IX/IY (DD/FD) opcode decoder.
- Tracks the DD/FD prefix, latches the following opcode byte into Source, runs the 5-bit XPT step counter, and gates the decoder through not_enable/is_Y.
- Consumes the decoder's PR_Reset_XPT, P2_Set_CM1 and P2_Reset_XIX/XIY pulses to close each indexed instruction.

Parameters:
- PREFIX_IX, 8'hDD, opcode byte selecting IX.
- PREFIX_IY, 8'hFD, opcode byte selecting IY.
- XPT_MAX, 31, saturation value of XPT.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- Fetch_Valid  in  1  opcode byte on Fetch_Data valid this cycle (M1 fetch complete).
- Fetch_Data  in  8  fetched opcode byte.
- Step_Enable  in  1  advance XPT by one T-step (deasserted during wait states).
- PR_Reset_XPT  in  1  decoder request: XPT to 0.
- P2_Set_CM1  in  1  decoder request: end instruction, next M1 begins.
- P2_Reset_XIX  in  1  decoder request: leave IX mode.
- P2_Reset_XIY  in  1  decoder request: leave IY mode.
- not_enable  out  1  active-low decoder enable.
- is_Y  out  1  0 = IX, 1 = IY.
- XPT  out  5  step counter.
- notXPT  out  5  bitwise inverse of XPT (registered, never combinational).
- Source  out  8  latched opcode byte following the prefix.
- notSource  out  8  bitwise inverse of Source (registered).
- Prefix_Pending  out  1  prefix seen, opcode not yet latched.
- Prefix_Drop  out  1  one-cycle pulse: prefix cancelled by CB/ED byte.
- XPT_Overflow  out  1  sticky: XPT hit XPT_MAX while Step_Enable was asserted.

Behaviour:
- Reset values:
  - state = IDLE, not_enable = 1, is_Y = 0.
  - XPT = 0, notXPT = 5'h1F.
  - Source = 0, notSource = 8'hFF.
  - Prefix_Pending = 0, Prefix_Drop = 0, XPT_Overflow = 0.
- States: IDLE, PREFIX, EXEC. not_enable = 0 only in EXEC.
- IDLE:
  - Fetch_Valid with PREFIX_IX -> PREFIX, is_Y = 0.
  - Fetch_Valid with PREFIX_IY -> PREFIX, is_Y = 1.
  - Any other byte: stay in IDLE, Source unchanged.
- PREFIX (Prefix_Pending = 1):
  - Fetch_Valid with DD/FD -> stay in PREFIX; is_Y is overwritten by the last prefix.
  - Fetch_Valid with 8'hCB or 8'hED -> IDLE with a one-cycle Prefix_Drop pulse; Source is not written.
  - Fetch_Valid with any other byte -> EXEC; Source = byte; XPT = 0.
  - Latency: Source, notSource and not_enable = 0 are all valid on the first edge after the Fetch_Valid cycle.
- EXEC, evaluated each cycle in this priority order (highest first):
  1. Exit: P2_Set_CM1, or P2_Reset_XIX with is_Y = 0, or P2_Reset_XIY with is_Y = 1.
     - Next state IDLE, not_enable = 1, XPT = 0.
     - If Fetch_Valid with a prefix byte arrives in the same cycle, go directly to PREFIX (prefix chaining, e.g. DD 21 nn nn DD ...).
  2. PR_Reset_XPT -> XPT = 0. Overrides Step_Enable in the same cycle.
  3. Step_Enable -> XPT + 1, saturating at XPT_MAX; XPT_Overflow is set when Step_Enable arrives with XPT == XPT_MAX.
- Mismatched reset (P2_Reset_XIY while is_Y = 0, or the reverse) is ignored in every state.
- Fetch_Valid while in EXEC is ignored unless it coincides with an exit.
- Step_Enable, PR_Reset_XPT and the exit pulses have no effect in IDLE or PREFIX; XPT holds at 0.
- XPT_Overflow clears only on reset.
- Asynchronous reset mid-instruction: all outputs return to reset values immediately; no pending prefix survives.
- The not* outputs always equal the bitwise inverse of their true outputs on every cycle, including during reset.

Test Plan:
- Fetch DD then 8'h21; 3 Step_Enable; P2_Reset_XIX -> is_Y = 0, Source = 21, notSource = DE, XPT 0->1->2->3, not_enable returns to 1, XPT = 0 after the exit.
- Fetch FD, DD, FD, then 8'h7E -> stays in PREFIX through the three prefixes, is_Y = 1, Source = 7E, EXEC entered one cycle after the 7E fetch.
- Fetch DD then 8'hCB -> one-cycle Prefix_Drop pulse, state IDLE, Source keeps its old value, not_enable = 1 throughout.
- EXEC with PR_Reset_XPT and Step_Enable both asserted at XPT = 5 -> XPT = 0; with 40 consecutive Step_Enable -> XPT saturates at 31 and XPT_Overflow = 1.
- In EXEC with is_Y = 0: P2_Reset_XIY -> ignored; P2_Set_CM1 together with Fetch_Valid of FD -> next state PREFIX with is_Y = 1.
- Assert reset mid-EXEC at XPT = 7 -> all outputs at reset values immediately (before the next edge); notXPT = 1F, notSource = FF.
